// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell stepped LSB-first across two
// WIDTH-bit operands, with a start/busy/done handshake around it.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Su,
    output logic             Ca
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             ca_q, ca_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Full-adder cell built as half adder + half adder + OR.
    logic ha0_s, ha0_c, ha1_s, ha1_c, cell_s, cell_c;
    assign ha0_s  = op_a_q[0] ^ op_b_q[0];
    assign ha0_c  = op_a_q[0] & op_b_q[0];
    assign ha1_s  = ha0_s ^ cy_q;
    assign ha1_c  = ha0_s & cy_q;
    assign cell_s = ha1_s;
    assign cell_c = ha0_c | ha1_c;

    always_comb begin
        // NOTE: every *_d gets its hold value first, so no path through the case leaves a latch.
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        ca_d    = ca_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_a_d  = A;
                    op_b_d  = B;
                    cy_d    = Cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d  = {cell_s, sum_q[WIDTH-1:1]};
                op_a_d = {1'b0, op_a_q[WIDTH-1:1]};
                op_b_d = {1'b0, op_b_q[WIDTH-1:1]};
                cy_d   = cell_c;
                if (cnt_q == LAST) begin
                    ca_d    = cell_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Handshake flags are registered copies of the next-state decode.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            ca_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            ca_q    <= ca_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Su   = sum_q;
    assign Ca   = ca_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH=8 and WIDTH=16,
// using immediate assertions at every comparison point.
module tb_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, cin8, busy8, done8, ca8;
    logic [7:0]  a8, b8, su8;
    logic        start16, cin16, busy16, done16, ca16;
    logic [15:0] a16, b16, su16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
        .busy(busy8), .done(done8), .Su(su8), .Ca(ca8)
    );

    serial_add_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16), .Cin(cin16),
        .busy(busy16), .done(done16), .Su(su16), .Ca(ca16)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] res(input bit wide);
        return wide ? 32'({ca16, su16}) : 32'({ca8, su8});
    endfunction

    // One start pulse, then wait (bounded) for done and check latency/result.
    task automatic op(input bit wide, input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic [16:0] expected, input logic prev_ca, input string tag);
        int n;
        int lat;
        lat = wide ? 17 : 9;
        @(negedge clk);
        if (wide) begin start16 = 1'b1; a16 = a;     b16 = b;     cin16 = cin; end
        else      begin start8  = 1'b1; a8  = a[7:0]; b8 = b[7:0]; cin8  = cin; end
        @(negedge clk);
        start8 = 1'b0; start16 = 1'b0;
        n = 1;
        check({tag, "_busy_c1"}, 32'(wide ? busy16 : busy8), 32'd1);
        check({tag, "_clr_c1"}, 32'(wide ? su16 : 16'(su8)), 32'd0);
        check({tag, "_cahold_c1"}, 32'(wide ? ca16 : ca8), 32'(prev_ca));
        while (!(wide ? done16 : done8) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_result"}, res(wide), 32'(expected));
        @(negedge clk);
        check({tag, "_done_end"}, 32'(wide ? done16 : done8), 32'd0);
        check({tag, "_busy_end"}, 32'(wide ? busy16 : busy8), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int last_done;
        int n_done;
        logic prev_done;
        logic [15:0] ra, rb;
        logic rc, prev_ca;
        logic [16:0] exp_sum;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'({ca8, su8}), 32'd0);
        rst = 1'b0;

        // Directed sums: {Ca,Su} hand-computed.
        op(0, 16'h00, 16'h00, 1'b0, 17'h000, 1'b0, "zero");
        op(0, 16'hFF, 16'h01, 1'b0, 17'h100, 1'b0, "ff_01");
        op(0, 16'hA5, 16'h5A, 1'b1, 17'h100, 1'b1, "a5_5a_c");
        op(0, 16'h3C, 16'h0F, 1'b0, 17'h04B, 1'b1, "3c_0f");

        // start held high: accepted every 10 cycles, done one cycle wide.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
        n_done = 0; last_done = -1; prev_done = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done8) begin
                check("held_prev_low", 32'(prev_done), 32'd0);
                check("held_phase", 32'(i % 10), 32'd9);
                check("held_result", 32'({ca8, su8}), 32'h002);
                n_done++;
                last_done = i;
            end
            prev_done = done8;
            if (i == 30) start8 = 1'b0;
        end
        check("held_count", 32'(n_done), 32'd3);
        check("held_last", 32'(last_done), 32'd29);
        @(negedge clk);
        check("held_idle", 32'(busy8), 32'd0);

        // A start while busy is dropped.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        @(negedge clk);
        start8 = 1'b0;
        n_done = 4;
        while (!done8 && n_done < 40) begin
            @(negedge clk);
            n_done++;
        end
        check("busy_drop_latency", 32'(n_done), 32'd9);
        check("busy_drop_result", 32'({ca8, su8}), 32'h030);
        repeat (3) begin
            @(negedge clk);
            check("busy_drop_no_retrigger", 32'({busy8, done8}), 32'd0);
        end

        // Reset in the 4th RUN cycle discards the operation.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy8), 32'd0);
        check("midrst_sum", 32'({ca8, su8}), 32'd0);
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) n_done++;
        end
        check("midrst_quiet", 32'(n_done), 32'd0);
        op(0, 16'h80, 16'h80, 1'b0, 17'h100, 1'b0, "80_80");

        // Random operands against a behavioural sum, both widths.
        prev_ca = 1'b1;
        for (int i = 0; i < 500; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            exp_sum = 17'(ra) + 17'(rb) + 17'(rc);
            op(0, ra, rb, rc, exp_sum, prev_ca, "rand8");
            prev_ca = exp_sum[8];
        end
        prev_ca = 1'b0;
        for (int i = 0; i < 500; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            exp_sum = 17'(ra) + 17'(rb) + 17'(rc);
            op(1, ra, rb, rc, exp_sum, prev_ca, "rand16");
            prev_ca = exp_sum[16];
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition sequencer. It owns a single one-bit full adder, built from two half adders plus an OR, and steps that adder across two WIDTH-bit operands, least-significant bit first. The carry is held in a flop between steps. It sits between a requester issuing start/operands and the consumer of Su/Ca, trading WIDTH cycles of latency for one adder cell's worth of logic. A start/busy/done handshake governs when operands are captured and when results are valid.

## Interface
Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on accepted start.
- B  input  WIDTH  operand B; captured on accepted start.
- Cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; Su/Ca valid.
- Su  output  WIDTH  sum, registered.
- Ca  output  1  carry-out, registered.

## Operation
- Datapath:
  - Operand shift registers opA and opB.
  - Carry flop cy.
  - Sum shift register, presented on Su.
  - Bit counter cnt, width $clog2(WIDTH).
- One-bit cell: s = opA[0]^opB[0]^cy; c = (opA[0]&opB[0]) | (cy&(opA[0]^opB[0])). Implement it as half adder, half adder, OR.
- FSM states and transitions:
  - IDLE: wait. On start=1, load opA←A, opB←B, cy←Cin, cnt←0, Su←0; go to RUN. On start=0, stay.
  - RUN: each cycle Su←{s, Su[WIDTH-1:1]}, opA/opB shift right by 1 (zero fill), cy←c, cnt←cnt+1. When cnt==WIDTH-1, go to DONE and also write Ca←c.
  - DONE: done=1 for this cycle only; next state IDLE unconditionally.
- start is ignored in RUN and DONE. No queuing; a request made while busy is lost, and the requester must retry.
- Su and Ca hold their last result from DONE until the next accepted start. On that start, Su clears to 0; Ca keeps its value until the end of the next operation.
- A, B and Cin may change freely after the start cycle.
- Arithmetic: {Ca,Su} = A + B + Cin, exact, modulo 2^(WIDTH+1). There is no overflow flag; Ca is the unsigned overflow.
- cnt never wraps in normal operation: it is reloaded to 0 on each accepted start.

## Timing
- Reset (rst=1 at an edge), from any state including mid-RUN: state←IDLE, busy=0, done=0, Su=0, Ca=0, cy=0, cnt=0. The partial result is discarded; no done pulse is produced.
- rst has priority over start on the same edge.
- Latency, with start accepted at edge E0:
  - busy=1 from after E0.
  - RUN occupies edges E1..E_WIDTH.
  - done=1 in the cycle after E_WIDTH, i.e. at edge count WIDTH+1 from acceptance.
  - busy falls after edge E_(WIDTH+1).
- Su/Ca are final and stable in the done cycle.
- Throughput: earliest next acceptance is the cycle after done, which gives one operation per WIDTH+2 cycles.
- busy and done are Moore outputs decoded from state; there is no combinational path from start.

## Test plan
- Reset, then WIDTH=8, A=0x00, B=0x00, Cin=0, start for 1 cycle -> busy for 9 cycles; done on the 9th post-start cycle; Su=0x00, Ca=0.
- A=0xFF, B=0x01, Cin=0 -> Su=0x00, Ca=1. Then A=0xA5, B=0x5A, Cin=1 -> Su=0x00, Ca=1. Then A=0x3C, B=0x0F, Cin=0 -> Su=0x4B, Ca=0.
- Hold start=1 continuously for 30 cycles with A=0x01, B=0x01 -> done pulses every 10 cycles, each a single cycle wide; Su=0x02, Ca=0 each time.
- Start with A=0x10, B=0x20, then 3 cycles later change A/B to 0xFF/0xFF and pulse start -> second start ignored; result Su=0x30, Ca=0.
- Start with A=0xFF, B=0xFF, Cin=1; assert rst on the 4th RUN cycle -> next cycle busy=0, Su=0x00, Ca=0; done never pulses. A fresh start of 0x80+0x80 then yields Su=0x00, Ca=1.
- Randomized: 500 random A/B/Cin at WIDTH=8 and WIDTH=16 -> {Ca,Su} matches A+B+Cin in every done cycle; done never asserts outside DONE.
